// File: rtl/kgp_fetch_sequencer.sv
// rtl/kgp_fetch_sequencer.sv - KGPRisc fetch/issue sequencer with next-PC logic and return-address stack
module kgp_fetch_sequencer #(
    parameter int              PC_W      = 32,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [5:0]      opcode,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            b,
    input  logic            br,
    input  logic            bz,
    input  logic            bnz,
    input  logic            bcy,
    input  logic            bncy,
    input  logic            bs,
    input  logic            bns,
    input  logic            bv,
    input  logic            bnv,
    input  logic            Call,
    input  logic            Ret,
    input  logic            zf,
    input  logic            cf,
    input  logic            sf,
    input  logic            vf,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc,
    output logic            ras_err
);

    localparam int               PTR_W = $clog2(RAS_DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {FETCH, ISSUE, WAIT_CTRL, RESOLVE} state_t;

    state_t           state;
    logic [PC_W-1:0]  ras [RAS_DEPTH];
    logic [PTR_W-1:0] head;
    logic [CNT_W-1:0] count;

    logic [PC_W-1:0]  seq_pc;
    logic [PC_W-1:0]  imm;
    logic [PC_W-1:0]  rel_pc;
    logic [PC_W-1:0]  next_pc;
    logic [PTR_W-1:0] top;
    logic             ras_empty;
    logic             ras_full;
    logic             cond_taken;
    logic             ras_push;

    assign imem_addr  = pc;
    assign seq_pc     = pc + PC_W'(1);
    assign imm        = PC_W'($signed(instr[21:0]));
    assign rel_pc     = seq_pc + imm;
    assign top        = head - PTR_W'(1);
    assign ras_empty  = (count == '0);
    assign ras_full   = (count == FULL);
    assign cond_taken = (bz && zf) || (bnz && !zf) || (bcy && cf) || (bncy && !cf)
                     || (bs && sf) || (bns && !sf) || (bv && vf) || (bnv && !vf);
    assign ras_push   = (state == RESOLVE) && !Ret && Call;

    // Ret > Call > br > b > conditionals > sequential
    always_comb begin
        next_pc = seq_pc;
        if (Ret) begin
            next_pc = ras_empty ? RESET_PC : ras[top];
        end else if (Call) begin
            next_pc = rel_pc;
        end else if (br) begin
            next_pc = br_target;
        end else if (b || cond_taken) begin
            next_pc = rel_pc;
        end
    end

    // Storage is only read when count says an entry is live, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras[head] <= seq_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= '0;
            opcode      <= '0;
            instr_valid <= 1'b0;
            head        <= '0;
            count       <= '0;
            ras_err     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    instr_valid <= 1'b0;
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_valid) begin
                        instr       <= imem_rdata;
                        opcode      <= imem_rdata[31:26];
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    instr_valid <= 1'b0;
                    if (!stall) begin
                        state <= WAIT_CTRL;
                    end
                end
                WAIT_CTRL: begin
                    state <= RESOLVE;
                end
                RESOLVE: begin
                    pc       <= next_pc;
                    imem_req <= 1'b1;
                    state    <= FETCH;
                    if (Ret) begin
                        if (ras_empty) begin
                            ras_err <= 1'b1;
                        end else begin
                            head  <= top;
                            count <= count - CNT_W'(1);
                        end
                    end else if (Call) begin
                        // A full stack wraps onto its oldest entry.
                        head <= head + PTR_W'(1);
                        if (ras_full) begin
                            ras_err <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_kgp_fetch_sequencer.sv
// tb/tb_kgp_fetch_sequencer.sv - self-checking bench for kgp_fetch_sequencer
module tb_kgp_fetch_sequencer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] word;
        int          lat;
        int          stl;
        logic [11:0] strb;
        logic [3:0]  flg;
        logic [31:0] tgt;
        logic [31:0] exp_next;
        logic        exp_err;
    } vec_t;

    // strobe vector: {Ret, Call, br, b, bz, bnz, bcy, bncy, bs, bns, bv, bnv}
    localparam logic [11:0] S_RET  = 12'h800;
    localparam logic [11:0] S_CALL = 12'h400;
    localparam logic [11:0] S_BR   = 12'h200;
    localparam logic [11:0] S_B    = 12'h100;
    localparam logic [11:0] S_BZ   = 12'h080;
    localparam logic [3:0]  F_Z    = 4'b1000;

    localparam logic [31:0] W_ADD  = 32'h0000_0123;
    localparam logic [31:0] W_BZM2 = 32'h403F_FFFE;
    localparam logic [31:0] W_BR   = 32'h0800_0000;
    localparam logic [31:0] W_C10  = 32'h0C00_000A;
    localparam logic [31:0] W_C0   = 32'h0C00_0000;
    localparam logic [31:0] W_C5   = 32'h0C00_0005;
    localparam logic [31:0] W_RET  = 32'h1000_0000;
    localparam logic [31:0] W_MIX  = 32'hA800_0014;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [5:0]  opcode;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic [11:0] strb;
    logic [3:0]  flg;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        ras_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_iv = -1;
    int prev_stl = 0;

    logic [31:0] exp_pc;
    logic        exp_err;
    logic [31:0] model_pc;
    logic        model_err;
    logic [31:0] ras_q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    kgp_fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .opcode(opcode), .instr(instr), .instr_valid(instr_valid), .stall(stall),
        .b(strb[8]), .br(strb[9]), .bz(strb[7]), .bnz(strb[6]), .bcy(strb[5]), .bncy(strb[4]),
        .bs(strb[3]), .bns(strb[2]), .bv(strb[1]), .bnv(strb[0]), .Call(strb[10]), .Ret(strb[11]),
        .zf(flg[3]), .cf(flg[2]), .sf(flg[1]), .vf(flg[0]),
        .br_target(br_target), .pc(pc), .ras_err(ras_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] w, input int lat, input int stl, input logic [11:0] s,
                                input logic [3:0] f, input logic [31:0] t, input logic [31:0] nx, input logic e);
        vec_t v;
        v.word = w; v.lat = lat; v.stl = stl; v.strb = s; v.flg = f; v.tgt = t; v.exp_next = nx; v.exp_err = e;
        return v;
    endfunction

    // Architectural next-PC model: a queue is the return stack, oldest entry at the front.
    task automatic model_step(input logic [31:0] w, input logic [11:0] s, input logic [3:0] f, input logic [31:0] t);
        logic [31:0] seq, rel;
        int          imm;
        bit          taken;
        seq   = model_pc + 32'd1;
        imm   = w[21] ? (int'(w[21:0]) - 4194304) : int'(w[21:0]);
        rel   = seq + imm;
        taken = (s[7] && f[3]) || (s[6] && !f[3]) || (s[5] && f[2]) || (s[4] && !f[2])
             || (s[3] && f[1]) || (s[2] && !f[1]) || (s[1] && f[0]) || (s[0] && !f[0]);
        if (s[11]) begin
            if (ras_q.size() == 0) begin
                model_pc  = 32'd0;
                model_err = 1'b1;
            end else begin
                model_pc = ras_q.pop_back();
            end
        end else if (s[10]) begin
            if (ras_q.size() == DEPTH) begin
                void'(ras_q.pop_front());
                model_err = 1'b1;
            end
            ras_q.push_back(seq);
            model_pc = rel;
        end else if (s[9]) begin
            model_pc = t;
        end else if (s[8] || taken) begin
            model_pc = rel;
        end else begin
            model_pc = seq;
        end
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = imem_req;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: imem_req stayed low, expected 1 within 20 cycles");
        end
    endtask

    task automatic run_instr(input vec_t v, input bit use_tbl);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        chk("imem_addr", imem_addr, exp_pc);
        chk("ras_err", ras_err, exp_err);
        strb = v.strb; flg = v.flg; br_target = v.tgt;
        for (int k = 0; k < v.lat; k++) begin
            @(negedge clk);
            chk("req_held", imem_req, 1);
        end
        imem_valid = 1'b1;
        imem_rdata = v.word;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        chk("instr_valid", instr_valid, 1);
        chk("instr", instr, v.word);
        chk("opcode", opcode, v.word[31:26]);
        chk("pc_hold", pc, exp_pc);
        if (last_iv >= 0) chk("issue_interval", cyc - last_iv, 4 + prev_stl + v.lat);
        last_iv  = cyc;
        prev_stl = v.stl;
        for (int k = 0; k < v.stl; k++) begin
            stall = 1'b1;
            @(negedge clk);
            chk("stall_no_pulse", instr_valid, 0);
            chk("stall_opcode", opcode, v.word[31:26]);
        end
        stall = 1'b0;
        model_step(v.word, v.strb, v.flg, v.tgt);
        if (use_tbl) begin
            exp_pc = v.exp_next; exp_err = v.exp_err;
        end else begin
            exp_pc = model_pc; exp_err = model_err;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit   ok;
        vec_t v;
        int   r;

        // pc 0..4 ADDs, bz imm=-2 at pc 5, br to 3, Call/Ret, Ret on empty stack
        tbl.push_back(mk(W_ADD,  0, 0, 0,      0,   0, 1,  0));
        tbl.push_back(mk(W_ADD,  0, 0, 0,      0,   0, 2,  0));
        tbl.push_back(mk(W_ADD,  0, 0, 0,      0,   0, 3,  0));
        tbl.push_back(mk(W_ADD,  1, 0, 0,      0,   0, 4,  0));
        tbl.push_back(mk(W_ADD,  2, 0, 0,      0,   0, 5,  0));
        tbl.push_back(mk(W_BZM2, 0, 0, S_BZ,   F_Z, 0, 4,  0));
        tbl.push_back(mk(W_ADD,  0, 0, 0,      0,   0, 5,  0));
        tbl.push_back(mk(W_BZM2, 0, 0, S_BZ,   0,   0, 6,  0));
        tbl.push_back(mk(W_BR,   0, 0, S_BR,   0,   3, 3,  0));
        tbl.push_back(mk(W_C10,  0, 0, S_CALL, 0,   0, 14, 0));
        tbl.push_back(mk(W_RET,  0, 0, S_RET,  0,   0, 4,  0));
        tbl.push_back(mk(W_RET,  0, 0, S_RET,  0,   0, 0,  1));
        // after reset: DEPTH+1 nested calls then DEPTH+1 returns
        tbl.push_back(mk(W_C0,   0, 0, S_CALL, 0,   0, 1,  0));
        tbl.push_back(mk(W_C0,   1, 0, S_CALL, 0,   0, 2,  0));
        tbl.push_back(mk(W_C0,   0, 0, S_CALL, 0,   0, 3,  0));
        tbl.push_back(mk(W_C0,   0, 0, S_CALL, 0,   0, 4,  0));
        tbl.push_back(mk(W_C0,   0, 0, S_CALL, 0,   0, 5,  1));
        tbl.push_back(mk(W_RET,  0, 0, S_RET,  0,   0, 5,  1));
        tbl.push_back(mk(W_RET,  0, 0, S_RET,  0,   0, 4,  1));
        tbl.push_back(mk(W_RET,  2, 0, S_RET,  0,   0, 3,  1));
        tbl.push_back(mk(W_RET,  0, 0, S_RET,  0,   0, 2,  1));
        tbl.push_back(mk(W_RET,  0, 0, S_RET,  0,   0, 0,  1));
        // Ret+Call+br+b together with a 3-cycle stall
        tbl.push_back(mk(W_C5,   0, 0, S_CALL, 0,   0, 6,  1));
        tbl.push_back(mk(W_MIX,  0, 3, S_RET | S_CALL | S_BR | S_B, 0, 50, 1, 1));

        rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0;
        strb = '0; flg = '0; br_target = '0;
        model_pc = 0; model_err = 0; exp_pc = 0; exp_err = 0;
        repeat (3) @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_ras_err", ras_err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("req_after_rst", imem_req, 1);

        for (int i = 0; i < 12; i++) run_instr(tbl[i], 1'b1);

        // async reset in the middle of a 2-cycle-latency fetch, response left pending
        wait_req(ok);
        chk("pre_rst_addr", imem_addr, exp_pc);
        @(negedge clk);
        rst = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = W_RET;
        #1;
        chk("async_req_drop", imem_req, 0);
        chk("async_pc", pc, 0);
        chk("async_ras_err", ras_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("pending_valid_ignored_req", imem_req, 1);
        chk("pending_valid_ignored_iv", instr_valid, 0);
        imem_valid = 1'b0;
        ras_q.delete();
        model_pc = 0; model_err = 0; exp_pc = 0; exp_err = 0;
        last_iv = -1;

        for (int i = 12; i < tbl.size(); i++) run_instr(tbl[i], 1'b1);

        exp_pc = model_pc; exp_err = model_err;
        for (int i = 0; i < 400; i++) begin
            v.word = $urandom;
            v.lat  = $urandom_range(0, 3);
            v.stl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            v.flg  = 4'($urandom);
            v.tgt  = $urandom;
            r = $urandom_range(0, 9);
            case (r)
                0:       v.strb = S_RET;
                1:       v.strb = S_CALL;
                2:       v.strb = S_BR;
                3:       v.strb = S_B;
                4, 5, 6: v.strb = 12'(1) << $urandom_range(0, 7);
                7:       v.strb = (12'(1) << $urandom_range(0, 7)) | (12'(1) << $urandom_range(0, 7));
                8:       v.strb = 12'($urandom);
                default: v.strb = '0;
            endcase
            v.exp_next = 0; v.exp_err = 0;
            run_instr(v, 1'b0);
        end

        wait_req(ok);
        chk("final_addr", imem_addr, exp_pc);
        chk("final_ras_err", ras_err, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
